lut_neuron_loader: RTL and testbench

- Runtime-programmable truth-table neuron: the writer side of the fixed-ROM LUT neurons.
- Accepts a truth table as a beat stream with a valid/ready handshake, fills a shadow table, then commits it atomically to the active table.
- Serves registered lookups with the same M0 (address) / M1 (output) semantics as generated layer neurons.
- Sits in the reconfigurable-layer fabric; a config DMA drives it, and the previous layer's packed activations feed M0.

---
 rtl/lut_loader_pkg.sv | 25 ++
 rtl/lut_table_bank.sv | 60 ++++++
 rtl/lut_neuron_loader.sv | 149 ++++++++++++++
 tb/tb_lut_neuron_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_loader_pkg.sv
// Shared types and sizing helpers for the runtime-loadable LUT neuron.
package lut_loader_pkg;

  localparam int DEF_IN_BITS  = 6;
  localparam int DEF_OUT_BITS = 1;
  localparam int DEF_LOAD_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    COMMIT
  } ld_state_t;

  // Number of load beats needed to fill one full table.
  function automatic int calc_beats(input int in_bits, input int out_bits, input int load_w);
    return ((2 ** in_bits) * out_bits) / load_w;
  endfunction

  // Beat counter width; one spare bit so the counter can reach BEATS without wrapping.
  function automatic int calc_cnt_w(input int beats);
    return $clog2(beats) + 1;
  endfunction

endpackage

// File: rtl/lut_table_bank.sv
// Shadow/active truth-table storage: slice writes into the shadow copy,
// single-cycle commit into the active copy, and a registered lookup port.
module lut_table_bank
  import lut_loader_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int LOAD_W   = DEF_LOAD_W,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [CNT_W-1:0]    wr_idx,
  input  logic [LOAD_W-1:0]   wr_data,
  input  logic                clear,
  input  logic                commit,
  input  logic                rd_en,
  input  logic [IN_BITS-1:0]  rd_addr,
  output logic                rd_valid,
  output logic [OUT_BITS-1:0] rd_data
);

  localparam int TBL_W = (2 ** IN_BITS) * OUT_BITS;

  logic [TBL_W-1:0] shadow;
  logic [TBL_W-1:0] active;

  // Shadow fill; an abort wipes whatever partial table was collected.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shadow <= '0;
    end else if (wr_en) begin
      shadow[int'(wr_idx) * LOAD_W +: LOAD_W] <= wr_data;
    end
  end

  // Atomic copy of the whole shadow table into the active table.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
    end else if (commit) begin
      active <= shadow;
    end
  end

  // Registered lookup; reads the pre-commit table in the commit cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= active[int'(rd_addr) * OUT_BITS +: OUT_BITS];
      end
    end
  end

endmodule

// File: rtl/lut_neuron_loader.sv
// Runtime-programmable truth-table neuron: beat-stream loader with abort
// handling plus a latency-1 lookup port.
// Optional beat parity check enabled by defining LUT_LOAD_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for the first beat of a table
// LOAD   | collecting beats 1..BEATS-1 into the shadow table
// DRAIN  | swallowing the rest of a rejected table up to cfg_last
// COMMIT | copying shadow into active; loader not ready
module lut_neuron_loader
  import lut_loader_pkg::*;
#(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int LOAD_W   = DEF_LOAD_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [LOAD_W-1:0]   cfg_data,
  input  logic                cfg_last,
`ifdef LUT_LOAD_PARITY_EN
  input  logic                cfg_par,
`endif
  output logic                cfg_err,
  output logic                table_loaded,
  input  logic                in_valid,
  input  logic [IN_BITS-1:0]  M0,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] M1
);

  localparam int BEATS = calc_beats(IN_BITS, OUT_BITS, LOAD_W);
  localparam int CNT_W = calc_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  ld_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] idx;
  logic             xfer;
  logic             par_bad;
  logic             wr_en;
  logic             clear;
  logic             commit;
  logic             err_nxt;

  // State, beat counter and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cfg_err      <= 1'b0;
      cfg_ready    <= 1'b0;
      table_loaded <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cfg_err   <= err_nxt;
      cfg_ready <= (state_nxt != COMMIT);
      if (commit) begin
        table_loaded <= 1'b1;
      end
    end
  end

  // Next-state logic; IDLE and LOAD share one path with IDLE writing slice 0,
  // which also covers a single-beat table.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    clear     = 1'b0;
    commit    = 1'b0;
    err_nxt   = 1'b0;
    xfer      = cfg_valid && cfg_ready;
    idx       = (state == LOAD) ? cnt : '0;
`ifdef LUT_LOAD_PARITY_EN
    par_bad   = (cfg_par != ^cfg_data);
`else
    par_bad   = 1'b0;
`endif
    case (state)
      IDLE, LOAD: begin
        if (xfer) begin
          if (par_bad) begin
            err_nxt   = 1'b1;
            clear     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = cfg_last ? IDLE : DRAIN;
          end else if (idx == LAST_IDX) begin
            if (cfg_last) begin
              wr_en     = 1'b1;
              cnt_nxt   = idx + 1'b1;
              state_nxt = COMMIT;
            end else begin
              err_nxt   = 1'b1;
              clear     = 1'b1;
              cnt_nxt   = '0;
              state_nxt = DRAIN;
            end
          end else if (cfg_last) begin
            err_nxt   = 1'b1;
            clear     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            wr_en     = 1'b1;
            cnt_nxt   = idx + 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      DRAIN: begin
        if (xfer && cfg_last) begin
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  lut_table_bank #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .LOAD_W   (LOAD_W),
    .CNT_W    (CNT_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_data  (cfg_data),
    .clear    (clear),
    .commit   (commit),
    .rd_en    (in_valid),
    .rd_addr  (M0),
    .rd_valid (out_valid),
    .rd_data  (M1)
  );

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Scoreboard bench for lut_neuron_loader at default parameters.
// Define LUT_LOAD_PARITY_EN to also exercise the parity abort path.
module tb_lut_neuron_loader;

  typedef struct {
    logic [5:0] addr;
    logic [0:0] exp;
  } lk_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_last;
  logic       in_valid;
  logic [5:0] M0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       table_loaded;
  logic       out_valid;
  logic [0:0] M1;
`ifdef LUT_LOAD_PARITY_EN
  logic       cfg_par;
`endif

  int  tests = 0;
  int  fails = 0;
  int  err_seen = 0;
  int  err_base = 0;
  lk_t exp_q[$];

  lut_neuron_loader dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
`ifdef LUT_LOAD_PARITY_EN
    .cfg_par      (cfg_par),
`endif
    .cfg_err      (cfg_err),
    .table_loaded (table_loaded),
    .in_valid     (in_valid),
    .M0           (M0),
    .out_valid    (out_valid),
    .M1           (M1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected lookup result per out_valid and counts error pulses.
  always @(negedge clk) begin
    if (cfg_err) err_seen++;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL lookup_unexpected: got out_valid=1 M1=%0h expected no result", M1);
      end else begin
        lk_t e;
        e = exp_q.pop_front();
        check($sformatf("lookup_M0_%02h", e.addr), 32'(M1), 32'(e.exp));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic par_ok = 1'b1);
    int n;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
`ifdef LUT_LOAD_PARITY_EN
    cfg_par   = par_ok ? ^d : ~^d;
`endif
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!cfg_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got cfg_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    if (par_ok) cfg_data = 8'h00;
  endtask

  task automatic send_table(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    logic [7:0] t [8];
    t = '{b0, b1, b2, b3, b4, b5, b6, b7};
    for (int i = 0; i < 8; i++) send_beat(t[i], i == 7);
  endtask

  task automatic lookup(input logic [5:0] a, input logic [0:0] e);
    lk_t it;
    it.addr = a;
    it.exp  = e;
    exp_q.push_back(it);
    in_valid = 1'b1;
    M0       = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_err(input string name, input int exp_delta);
    idle(3);
    check(name, 32'(err_seen - err_base), 32'(exp_delta));
    err_base = err_seen;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    M0        = '0;
`ifdef LUT_LOAD_PARITY_EN
    cfg_par   = 1'b0;
`endif
    idle(3);
    check("rst_cfg_ready", 32'(cfg_ready), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    check("rst_table_loaded", 32'(table_loaded), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_M1", 32'(M1), 0);
    rst = 1'b0;
    idle(2);

    // Empty table after reset
    lookup(6'h00, 1'b0);
    lookup(6'h2D, 1'b0);
    lookup(6'h3F, 1'b0);
    idle(1);
    check("loaded_before_any", 32'(table_loaded), 0);

    // Single set bit: beat 1 bit 5 -> entry 13
    send_table(8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(2);
    check("loaded_after_first", 32'(table_loaded), 1);
    lookup(6'h0D, 1'b1);
    lookup(6'h0C, 1'b0);
    lookup(6'h00, 1'b0);
    check_err("err_none_good_load", 0);

    // Short table: cfg_last on beat 3
    for (int i = 0; i < 4; i++) send_beat(8'hFF, i == 3);
    check_err("err_short", 1);
    lookup(6'h0D, 1'b1);
    lookup(6'h0C, 1'b0);

    // Overlong table: 10 beats, last on beat 9, two drained
    for (int i = 0; i < 10; i++) send_beat(8'hFF, i == 9);
    check_err("err_overlong", 1);
    lookup(6'h0D, 1'b1);
    lookup(6'h3F, 1'b0);

    // Correct load after drain: all zero
    send_table(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    idle(2);
    lookup(6'h0D, 1'b0);
    check_err("err_after_drain_load", 0);

    // All-ones over all-zero: commit-cycle lookup sees old table
    send_table(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    fork
      lookup(6'h0D, 1'b0);
      begin
        @(negedge clk);
        check("ready_in_commit", 32'(cfg_ready), 0);
      end
    join
    lookup(6'h0D, 1'b1);
    lookup(6'h00, 1'b1);
    lookup(6'h3F, 1'b1);

    // Gapped beats with junk on the bus while cfg_valid is low
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      int gap;
      b = (i == 0) ? 8'h01 : (i == 7) ? 8'h80 : 8'h00;
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        cfg_data = 8'($urandom);
        cfg_last = 1'($urandom);
        idle(1);
      end
      cfg_last = 1'b0;
      send_beat(b, i == 7);
    end
    idle(2);
    lookup(6'h00, 1'b1);
    lookup(6'h3F, 1'b1);
    lookup(6'h0D, 1'b0);
    lookup(6'h01, 1'b0);
    check_err("err_gapped", 0);

`ifdef LUT_LOAD_PARITY_EN
    // Bad parity on beat 4: abort, drain the rest, active keeps prior table
    for (int i = 0; i < 8; i++) send_beat(8'h5A, i == 7, i != 4);
    check_err("err_parity", 1);
    lookup(6'h00, 1'b1);
    lookup(6'h3F, 1'b1);
    lookup(6'h0D, 1'b0);
`endif

    // Reset at beat 5 of a load
    for (int i = 0; i < 5; i++) send_beat(8'hFF, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    check("loaded_after_midrst", 32'(table_loaded), 0);
    lookup(6'h00, 1'b0);
    lookup(6'h3F, 1'b0);
    lookup(6'h0D, 1'b0);

    idle(4);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
